// File: rtl/ram_test_pkg.sv
// Shared types and helpers for the SDRAM pattern tester.
// The pattern mixes low and high address bits so that both row and column lines toggle.
package ram_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_REFRESH,
        ST_DONE
    } state_t;

    localparam logic [1:0] DS_IDLE   = 2'b11;
    localparam logic [1:0] DS_ACTIVE = 2'b00;

    function automatic logic [15:0] pat(input logic [15:0] lo,
                                        input logic [7:0]  hi,
                                        input logic        phase);
        return lo ^ {hi, 8'h00} ^ {16{phase}};
    endfunction

endpackage

// File: rtl/ram_pattern_tester_slot_timer.sv
// Access-slot cycle counter plus refresh-interval down-counter for the RAM pattern tester.
// The cycle counter parks at 0 whenever run is low, so the first busy cycle is always slot cycle 0.
module slot_timer #(
    parameter int SLOT_LEN  = 4,
    parameter int RD_SAMPLE = 3,
    parameter int REF_EVERY = 8
) (
    input  logic clk_32,
    input  logic reset,
    input  logic run,
    input  logic acc_end,
    output logic slot_start,
    output logic slot_last,
    output logic sample_en,
    output logic ref_due
);

    localparam int CW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int RW = $clog2(REF_EVERY + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(SLOT_LEN - 1);
    localparam logic [CW-1:0] CNT_SAMPLE = CW'(RD_SAMPLE);
    localparam logic [RW-1:0] REF_LOAD   = RW'(REF_EVERY - 1);

    logic [CW-1:0] cnt;
    logic [RW-1:0] ref_cnt;

    always_ff @(posedge clk_32 or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!run || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Terminal count marks the access slot that closes a refresh interval.
    always_ff @(posedge clk_32 or posedge reset) begin
        if (reset) begin
            ref_cnt <= REF_LOAD;
        end else if (acc_end) begin
            ref_cnt <= (ref_cnt == '0) ? REF_LOAD : ref_cnt - 1'b1;
        end
    end

    assign slot_start = run && (cnt == '0);
    assign slot_last  = run && (cnt == CNT_LAST);
    assign sample_en  = run && (cnt == CNT_SAMPLE);
    assign ref_due    = (ref_cnt == '0);

endmodule

// File: rtl/ram_pattern_tester.sv
// Board bring-up bus master: writes a pattern, reads it back, then repeats inverted.
// Bus outputs decode straight from flops so an async reset drops cs without waiting for a clock.
//
// state      | meaning
// ST_IDLE    | waiting for ram_ready && start, addr parked at 0
// ST_WRITE   | one write slot per word, din = pat(addr)
// ST_READ    | one read slot per word, dout compared at RD_SAMPLE
// ST_REFRESH | one refresh slot, then back to ret_state at the same addr
// ST_DONE    | pass pair finished (LOOP=0); waits for start low then high
module ram_pattern_tester
    import ram_test_pkg::*;
#(
    parameter int ADDR_W          = 22,
    parameter int TEST_WORDS_LOG2 = 22,
    parameter int SLOT_LEN        = 4,
    parameter int RD_SAMPLE       = 3,
    parameter int REF_EVERY       = 8,
    parameter bit LOOP            = 1'b1
) (
    input  logic              clk_32,
    input  logic              reset,
    input  logic              ram_ready,
    input  logic              start,
    output logic              cs,
    output logic              we,
    output logic [1:0]        ds,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       din,
    input  logic [15:0]       dout,
    output logic              refresh,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] err_addr,
    output logic [15:0]       err_data,
    output logic [7:0]        pass_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR =
        ADDR_W'((64'd1 << TEST_WORDS_LOG2) - 64'd1);

    state_t            state, state_nxt;
    state_t            ret_state, ret_nxt;
    state_t            seq;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic              phase, phase_nxt;
    logic              pass_end;
    logic              acc_end;
    logic              stop_req;
    logic              start_low_seen;
    logic              rd_ok;
    logic              halt;
    logic              slot_start, slot_last, sample_en, ref_due;
    logic [15:0]       exp_pat;
    logic              mism;

    slot_timer #(
        .SLOT_LEN  (SLOT_LEN),
        .RD_SAMPLE (RD_SAMPLE),
        .REF_EVERY (REF_EVERY)
    ) u_slot_timer (
        .clk_32     (clk_32),
        .reset      (reset),
        .run        (busy),
        .acc_end    (acc_end),
        .slot_start (slot_start),
        .slot_last  (slot_last),
        .sample_en  (sample_en),
        .ref_due    (ref_due)
    );

    assign busy    = (state == ST_WRITE) || (state == ST_READ) || (state == ST_REFRESH);
    assign halt    = stop_req || !start || !ram_ready;
    assign exp_pat = pat(addr_q[15:0], addr_q[ADDR_W-1 -: 8], phase);

    always_ff @(posedge clk_32 or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            ret_state <= ST_WRITE;
            addr_q    <= '0;
            phase     <= 1'b0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            addr_q    <= addr_nxt;
            phase     <= phase_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ret_nxt   = ret_state;
        addr_nxt  = addr_q;
        phase_nxt = phase;
        pass_end  = 1'b0;
        acc_end   = 1'b0;
        seq       = state;
        case (state)
            ST_IDLE: begin
                if (ram_ready && start) state_nxt = ST_WRITE;
            end
            ST_WRITE, ST_READ: begin
                if (slot_last) begin
                    acc_end = 1'b1;
                    if (addr_q != LAST_ADDR) begin
                        addr_nxt = addr_q + 1'b1;
                        seq      = state;
                    end else if (state == ST_WRITE) begin
                        addr_nxt = '0;
                        seq      = ST_READ;
                    end else begin
                        addr_nxt  = '0;
                        pass_end  = 1'b1;
                        phase_nxt = ~phase;
                        seq       = LOOP ? ST_WRITE : ST_DONE;
                    end
                    if (halt) begin
                        state_nxt = ST_IDLE;
                        addr_nxt  = '0;
                    end else if (seq == ST_DONE) begin
                        state_nxt = ST_DONE;
                    end else if (ref_due) begin
                        state_nxt = ST_REFRESH;
                        ret_nxt   = seq;
                    end else begin
                        state_nxt = seq;
                    end
                end
            end
            ST_REFRESH: begin
                if (slot_last) begin
                    if (halt) begin
                        state_nxt = ST_IDLE;
                        addr_nxt  = '0;
                    end else begin
                        state_nxt = ret_state;
                    end
                end
            end
            ST_DONE: begin
                if (start_low_seen && start && ram_ready) state_nxt = ST_WRITE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // rd_ok remembers whether ram_ready held since the slot began, so a dip
    // anywhere before the sample point cancels that compare.
    always_ff @(posedge clk_32 or posedge reset) begin
        if (reset) begin
            stop_req       <= 1'b0;
            start_low_seen <= 1'b0;
            rd_ok          <= 1'b0;
        end else begin
            stop_req       <= busy && (state_nxt != ST_IDLE) && halt;
            start_low_seen <= (state == ST_DONE) && (start_low_seen || !start);
            rd_ok          <= slot_start ? ram_ready : (rd_ok && ram_ready);
        end
    end

    assign mism = (state == ST_READ) && sample_en && ram_ready &&
                  (slot_start || rd_ok) && (dout != exp_pat);

    always_ff @(posedge clk_32 or posedge reset) begin
        if (reset) begin
            done      <= 1'b0;
            error     <= 1'b0;
            err_count <= '0;
            err_addr  <= '0;
            err_data  <= '0;
            pass_cnt  <= '0;
        end else begin
            if (pass_end) begin
                done     <= 1'b1;
                pass_cnt <= pass_cnt + 1'b1;
            end
            if (mism) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 1'b1;
                if (!error) begin
                    error    <= 1'b1;
                    err_addr <= addr_q;
                    err_data <= dout;
                end
            end
        end
    end

    assign cs      = ((state == ST_WRITE) || (state == ST_READ)) && !slot_last;
    assign refresh = (state == ST_REFRESH) && !slot_last;
    assign ds      = cs ? DS_ACTIVE : DS_IDLE;
    assign we      = (state == ST_WRITE);
    assign din     = (state == ST_WRITE) ? exp_pat : 16'h0000;
    assign addr    = addr_q;

endmodule

// File: tb/tb_ram_pattern_tester.sv
// Directed bench: two testers (LOOP=0 and LOOP=1) share stimulus, each with its own ideal RAM.
module tb_ram_pattern_tester;

    logic        clk_32 = 1'b0;
    logic        reset;
    logic        ram_ready;
    logic        start;
    logic        corrupt;

    logic        cs_a, we_a, refresh_a, busy_a, done_a, error_a;
    logic [1:0]  ds_a;
    logic [21:0] addr_a, err_addr_a;
    logic [15:0] din_a, dout_a, err_count_a, err_data_a;
    logic [7:0]  pass_cnt_a;

    logic        cs_b, we_b, refresh_b, busy_b, done_b, error_b;
    logic [1:0]  ds_b;
    logic [21:0] addr_b, err_addr_b;
    logic [15:0] din_b, dout_b, err_count_b, err_data_b;
    logic [7:0]  pass_cnt_b;

    logic [15:0] mem_a [0:15];
    logic [15:0] mem_b [0:15];

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [22:0] slot_q [$];
    logic        rec_en = 1'b0;
    logic        prev_act = 1'b0;
    logic        got5_a = 1'b0, got5_b = 1'b0;
    logic [15:0] din5_a = '0, din5_b = '0;

    always #5 clk_32 = ~clk_32;

    ram_pattern_tester #(
        .ADDR_W(22), .TEST_WORDS_LOG2(4), .SLOT_LEN(4),
        .RD_SAMPLE(3), .REF_EVERY(8), .LOOP(1'b0)
    ) dut (
        .clk_32(clk_32), .reset(reset), .ram_ready(ram_ready), .start(start),
        .cs(cs_a), .we(we_a), .ds(ds_a), .addr(addr_a), .din(din_a), .dout(dout_a),
        .refresh(refresh_a), .busy(busy_a), .done(done_a), .error(error_a),
        .err_count(err_count_a), .err_addr(err_addr_a), .err_data(err_data_a),
        .pass_cnt(pass_cnt_a)
    );

    ram_pattern_tester #(
        .ADDR_W(22), .TEST_WORDS_LOG2(4), .SLOT_LEN(4),
        .RD_SAMPLE(3), .REF_EVERY(8), .LOOP(1'b1)
    ) dut_loop (
        .clk_32(clk_32), .reset(reset), .ram_ready(ram_ready), .start(start),
        .cs(cs_b), .we(we_b), .ds(ds_b), .addr(addr_b), .din(din_b), .dout(dout_b),
        .refresh(refresh_b), .busy(busy_b), .done(done_b), .error(error_b),
        .err_count(err_count_b), .err_addr(err_addr_b), .err_data(err_data_b),
        .pass_cnt(pass_cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Ideal RAM, one-cycle read latency; corrupt forces a bad word at addr 9.
    always @(posedge clk_32) begin
        if (cs_a && we_a) mem_a[addr_a[3:0]] <= din_a;
        if (cs_a && !we_a)
            dout_a <= (corrupt && addr_a == 22'd9) ? 16'hFFFF : mem_a[addr_a[3:0]];
        if (cs_b && we_b) mem_b[addr_b[3:0]] <= din_b;
        if (cs_b && !we_b)
            dout_b <= (corrupt && addr_b == 22'd9) ? 16'hFFFF : mem_b[addr_b[3:0]];
    end

    always @(negedge clk_32) begin
        if (!reset) begin
            if (cs_a || refresh_a) check("cs_refresh_overlap", {31'd0, cs_a & refresh_a}, 32'd0);
            if (cs_a) check("ds_active", {30'd0, ds_a}, 32'd0);
            if (refresh_a) check("ds_idle_refresh", {30'd0, ds_a}, 32'd3);
            if (rec_en && (cs_a || refresh_a) && !prev_act && slot_q.size() < 12)
                slot_q.push_back({refresh_a, addr_a});
            if (cs_a && we_a && addr_a == 22'd5 && !got5_a) begin
                din5_a = din_a;
                got5_a = 1'b1;
            end
            if (cs_b && we_b && addr_b == 22'd5 && pass_cnt_b == 8'd1 && !got5_b) begin
                din5_b = din_b;
                got5_b = 1'b1;
            end
        end
        prev_act = cs_a || refresh_a;
    end

    initial begin
        reset     = 1'b1;
        ram_ready = 1'b0;
        start     = 1'b0;
        corrupt   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        dout_a = '0;
        dout_b = '0;
        #1;
        check("rst_cs",        {31'd0, cs_a},       32'd0);
        check("rst_ds",        {30'd0, ds_a},       32'd3);
        check("rst_we",        {31'd0, we_a},       32'd0);
        check("rst_addr",      {10'd0, addr_a},     32'd0);
        check("rst_din",       {16'd0, din_a},      32'd0);
        check("rst_refresh",   {31'd0, refresh_a},  32'd0);
        check("rst_busy",      {31'd0, busy_a},     32'd0);
        check("rst_done",      {31'd0, done_a},     32'd0);
        check("rst_err_count", {16'd0, err_count_a}, 32'd0);
        check("rst_pass_cnt",  {24'd0, pass_cnt_a}, 32'd0);

        // Clean pass: start before ram_ready must not begin the test.
        repeat (3) @(negedge clk_32);
        reset  = 1'b0;
        start  = 1'b1;
        rec_en = 1'b1;
        repeat (3) @(negedge clk_32);
        check("wait_ram_ready", {31'd0, busy_a}, 32'd0);
        ram_ready = 1'b1;
        for (int i = 0; i < 2000 && !done_a; i++) @(negedge clk_32);
        check("pass1_done",      {31'd0, done_a},      32'd1);
        check("pass1_pass_cnt",  {24'd0, pass_cnt_a},  32'd1);
        check("pass1_error",     {31'd0, error_a},     32'd0);
        check("pass1_err_count", {16'd0, err_count_a}, 32'd0);
        check("pass1_busy",      {31'd0, busy_a},      32'd0);
        check("din_at_5",        {16'd0, din5_a},      32'h0005);
        rec_en = 1'b0;
        check("slot_count", {31'd0, slot_q.size() >= 10}, 32'd1);
        if (slot_q.size() >= 10) begin
            for (int i = 0; i < 8; i++)
                check("slot_write_seq", {9'd0, slot_q[i]}, i);
            check("slot8_is_refresh", {31'd0, slot_q[8][22]}, 32'd1);
            check("slot9_resume",     {9'd0, slot_q[9]},      32'd8);
        end

        for (int i = 0; i < 2000 && pass_cnt_b < 8'd2; i++) @(negedge clk_32);
        check("loop_pass_cnt", {24'd0, pass_cnt_b}, 32'd2);
        check("loop_error",    {31'd0, error_b},    32'd0);
        check("loop_din_at_5", {16'd0, din5_b},     32'hFFFA);
        check("done_holds_busy", {31'd0, busy_a},   32'd0);
        check("done_holds_cs",   {31'd0, cs_a},     32'd0);

        // DONE leaves only on start low then high.
        start = 1'b0;
        repeat (2) @(negedge clk_32);
        check("done_start_low", {31'd0, busy_a}, 32'd0);
        start = 1'b1;
        repeat (2) @(negedge clk_32);
        check("done_reenter", {31'd0, busy_a}, 32'd1);

        // Corrupted read at addr 9.
        reset   = 1'b1;
        corrupt = 1'b1;
        @(negedge clk_32);
        reset = 1'b0;
        for (int i = 0; i < 2000 && !done_a; i++) @(negedge clk_32);
        check("bad_done",      {31'd0, done_a},      32'd1);
        check("bad_error",     {31'd0, error_a},     32'd1);
        check("bad_err_addr",  {10'd0, err_addr_a},  32'd9);
        check("bad_err_data",  {16'd0, err_data_a},  32'hFFFF);
        check("bad_err_count", {16'd0, err_count_a}, 32'd1);
        check("bad_pass_cnt",  {24'd0, pass_cnt_a},  32'd1);
        for (int i = 0; i < 2000 && pass_cnt_b < 8'd2; i++) @(negedge clk_32);
        check("loop_bad_err_count", {16'd0, err_count_b}, 32'd2);
        check("loop_bad_err_addr",  {10'd0, err_addr_b},  32'd9);
        check("loop_bad_err_data",  {16'd0, err_data_b},  32'hFFFF);

        // Async reset in the middle of a read slot.
        for (int i = 0; i < 2000 && !(cs_b && !we_b); i++) @(negedge clk_32);
        check("mid_read_reached", {31'd0, cs_b && !we_b}, 32'd1);
        reset = 1'b1;
        #1;
        check("arst_cs",        {31'd0, cs_b},        32'd0);
        check("arst_ds",        {30'd0, ds_b},        32'd3);
        check("arst_busy",      {31'd0, busy_b},      32'd0);
        check("arst_done",      {31'd0, done_b},      32'd0);
        check("arst_error",     {31'd0, error_b},     32'd0);
        check("arst_err_count", {16'd0, err_count_b}, 32'd0);
        check("arst_err_addr",  {10'd0, err_addr_b},  32'd0);
        check("arst_err_data",  {16'd0, err_data_b},  32'd0);
        check("arst_pass_cnt",  {24'd0, pass_cnt_b},  32'd0);
        corrupt = 1'b0;
        @(negedge clk_32);
        reset = 1'b0;

        // Drop start at slot cycle 1 of the write to addr 3.
        for (int i = 0; i < 200 && !(cs_a && we_a && addr_a == 22'd3); i++) @(negedge clk_32);
        check("stop_slot_reached", {31'd0, cs_a && we_a && addr_a == 22'd3}, 32'd1);
        @(posedge clk_32);
        #1 start = 1'b0;
        @(negedge clk_32);
        check("stop_cs_cyc1", {31'd0, cs_a}, 32'd1);
        @(negedge clk_32);
        check("stop_cs_cyc2", {31'd0, cs_a}, 32'd1);
        @(negedge clk_32);
        check("stop_cs_cyc3",   {31'd0, cs_a},   32'd0);
        check("stop_busy_cyc3", {31'd0, busy_a}, 32'd1);
        @(negedge clk_32);
        check("stop_idle_busy", {31'd0, busy_a}, 32'd0);
        check("stop_idle_addr", {10'd0, addr_a}, 32'd0);
        check("stop_idle_cs",   {31'd0, cs_a},   32'd0);
        repeat (5) @(negedge clk_32);
        check("stop_stays_idle", {31'd0, busy_a}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_pattern_tester.md
Name: ram_pattern_tester

Overview:
- Bus master that feeds the sdram controller's chipset-side port (cs/we/ds/addr/din/dout/refresh) in place of the ST chipset for board-level RAM bring-up.
- Writes a pattern over a configurable word range, reads it back and compares, then repeats with the inverted pattern.
- Reports progress and errors through status outputs suitable for LEDs or a debug overlay.
- Runs in the clk_32 domain; accesses are paced in 4-clock slots, like the ST bus cycle.

Parameters:
- ADDR_W, 22, word address width of the sdram port.
- TEST_WORDS_LOG2, 22, log2 of tested words; range is 0 .. 2^TEST_WORDS_LOG2-1, with TEST_WORDS_LOG2 <= ADDR_W.
- SLOT_LEN, 4, clocks per access slot (minimum 3).
- RD_SAMPLE, 3, slot cycle index (0-based) at which dout is sampled; must be < SLOT_LEN.
- REF_EVERY, 8, number of access slots between refresh slots.
- LOOP, 1, if 1 the test restarts after each successful pass pair; if 0 it stops in DONE.

Ports:
- clk_32, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- ram_ready, in, 1, sdram controller finished initialisation.
- start, in, 1, level; test runs while high.
- cs, out, 1, access request to sdram.
- we, out, 1, write request, qualified by cs.
- ds, out, 2, active-low byte strobes {upper, lower}.
- addr, out, ADDR_W, word address.
- din, out, 16, write data to sdram.
- dout, in, 16, read data from sdram.
- refresh, out, 1, refresh request.
- busy, out, 1, test in progress.
- done, out, 1, at least one write/read pass pair completed.
- error, out, 1, sticky mismatch flag.
- err_count, out, 16, saturating mismatch count.
- err_addr, out, ADDR_W, address of the first mismatch.
- err_data, out, 16, data read at the first mismatch.
- pass_cnt, out, 8, completed pass pairs, wraps at 255 to 0.

Behaviour:
- Reset values: all outputs 0 except ds=2'b11; state IDLE.
- States: IDLE, WRITE, READ, REFRESH, DONE.
- IDLE:
  - Moves to WRITE when ram_ready && start.
  - On entry from reset, phase is 0 and addr is 0.
- Slot timer counts 0..SLOT_LEN-1; every access occupies exactly one slot.
  - cs is high for cycles 0..SLOT_LEN-2 and low for the last cycle.
  - ds=2'b00 while cs is high; ds=2'b11 otherwise.
  - addr and din are stable for the whole slot.
- Pattern: pat(a) = a[15:0] ^ {a[ADDR_W-1:ADDR_W-8], 8'h00} ^ {16{phase}}.
  - phase toggles per pass pair: 0 = true pattern, 1 = inverted.
- WRITE:
  - we=1, din=pat(addr).
  - addr increments at slot end; after the last word, addr resets to 0 and the state goes to READ.
- READ:
  - we=0, din=0.
  - At slot cycle RD_SAMPLE, compare dout with pat(addr).
  - On mismatch: err_count += 1 (saturating at 16'hFFFF).
  - On the first mismatch since reset: error=1, latch err_addr and err_data.
  - After the last word: pass_cnt += 1, done=1, phase toggles, then go to WRITE (LOOP=1) or DONE (LOOP=0).
- REFRESH:
  - After every REF_EVERY completed access slots in WRITE or READ, insert one slot with cs=0 and refresh=1 for cycles 0..SLOT_LEN-2.
  - Then resume the interrupted state at the same addr.
  - The refresh counter is not reset at WRITE/READ boundaries.
- busy=1 in WRITE, READ and REFRESH.
- start falling: the current slot completes, then the block returns to IDLE with addr=0.
  - phase, pass_cnt and error state are kept.
  - cs is never truncated mid-slot.
- ram_ready falling mid-test:
  - Treated like start falling.
  - Additionally the current read compare is suppressed if it had not yet been sampled.
- DONE: holds outputs idle; leaves only via reset, or by start going low then high (re-enters WRITE).
- Async reset mid-slot: cs drops immediately (combinational reset of registered outputs).

Decomposition:
- Package ram_test_pkg:
  - state enum typedef.
  - pattern function pat().
  - constants for ds idle/active values.
- One sub-module: slot_timer.
  - Slot cycle counter plus refresh-interval counter.
  - Outputs slot_start, slot_last, sample_en, ref_due.
  - Parameterised by SLOT_LEN, RD_SAMPLE and REF_EVERY.

Test Plan:
- Ideal RAM model (1-cycle read latency), TEST_WORDS_LOG2=4, LOOP=0, start=1 after ram_ready → 16 writes then 16 reads; din at addr 5 = 16'h0005; done=1, pass_cnt=1, error=0, err_count=0.
- Same setup, model corrupts the read at addr 9 to 16'hFFFF → error=1, err_addr=9, err_data=16'hFFFF, err_count=1.
- LOOP=1 → second pass writes 16'hFFFA at addr 5 (inverted pattern); pass_cnt reaches 2 with error=0.
- REF_EVERY=8 → a refresh slot appears after exactly 8 access slots; cs=0 during refresh; the next write resumes at addr 8; no two slots ever have cs and refresh both high.
- Drop start at slot cycle 1 of the write to addr 3 → cs stays high through cycle SLOT_LEN-2, then the block enters IDLE; busy=0, addr=0.
- Async reset asserted mid-READ → cs=0 and ds=2'b11 in the same cycle; all status outputs cleared.
